// File: rtl/aprop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aprop_pkg
// Description : Shared types and constants for the Propeller-style pin hub:
//               wait-unit state encoding, wait-mode constants and defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package aprop_pkg;

    // Default pins per port and the largest supported cog count.
    localparam int DEFAULT_PIN_W = 32;
    localparam int MAX_COGS      = 8;

    // Pin-wait unit states.
    typedef enum logic [0:0] {
        WAIT_ST_IDLE = 1'b0,
        WAIT_ST_WAIT = 1'b1
    } wait_state_e;

    // Wait modes: complete on equal, or complete on not-equal.
    localparam logic WAIT_MODE_EQ = 1'b0;
    localparam logic WAIT_MODE_NE = 1'b1;

endpackage : aprop_pkg
`default_nettype wire

// File: rtl/aprop_wait_unit.sv
`default_nettype none
// ============================================================================
// Module      : aprop_wait_unit
// Description : One WAITPEQ/WAITPNE pin-wait engine. Latches mode, mask and
//               masked compare value on a request, then compares the
//               synchronised pins every cycle until the condition holds or
//               the wait is cancelled.
// Revision    : 1.0 - initial release
// ============================================================================
module aprop_wait_unit
    import aprop_pkg::*;
#(
    parameter int PIN_W = DEFAULT_PIN_W
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             req_i,
    input  logic             mode_i,
    input  logic [PIN_W-1:0] mask_i,
    input  logic [PIN_W-1:0] value_i,
    input  logic             cancel_i,
    input  logic [PIN_W-1:0] pins_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [PIN_W-1:0] pins_o
);

    wait_state_e      state_q;
    logic             mode_q;
    logic [PIN_W-1:0] mask_q;
    logic [PIN_W-1:0] value_q;
    logic             busy_q;
    logic             done_q;
    logic [PIN_W-1:0] pins_q;

    logic             match;
    logic             hit;

    // Compare the masked live pins against the latched value; NE inverts the sense.
    always_comb begin
        match = ((pins_i & mask_q) == value_q);
        hit   = (mode_q == WAIT_MODE_NE) ? ~match : match;
    end

    // Wait FSM with operand latches, registered busy/done and pin capture.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= WAIT_ST_IDLE;
            mode_q  <= WAIT_MODE_EQ;
            mask_q  <= '0;
            value_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pins_q  <= '0;
        end else begin
            // Completion is a single-cycle pulse.
            done_q <= 1'b0;
            case (state_q)
                WAIT_ST_IDLE: begin
                    // A cancel in the same cycle suppresses the request.
                    if (req_i && !cancel_i) begin
                        mode_q  <= mode_i;
                        mask_q  <= mask_i;
                        value_q <= value_i & mask_i;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_ST_WAIT;
                    end
                end
                WAIT_ST_WAIT: begin
                    // Cancel takes priority over a coincident match; new
                    // requests are ignored so latched operands stay put.
                    if (cancel_i) begin
                        busy_q  <= 1'b0;
                        state_q <= WAIT_ST_IDLE;
                    end else if (hit) begin
                        done_q  <= 1'b1;
                        pins_q  <= pins_i;
                        busy_q  <= 1'b0;
                        state_q <= WAIT_ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= WAIT_ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign pins_o = pins_q;

endmodule : aprop_wait_unit
`default_nettype wire

// File: rtl/aprop_port_hub.sv
`default_nettype none
// ============================================================================
// Module      : aprop_port_hub
// Description : Pin hub between NUM_COGS cogs and the shared I/O pins.
//               Merges per-cog OUT/DIR into registered pad drive/enable,
//               synchronises the pad inputs for all cogs and hosts one
//               pin-wait unit per cog.
// Revision    : 1.0 - initial release
// ============================================================================
module aprop_port_hub
    import aprop_pkg::*;
#(
    parameter int NUM_COGS    = 2,
    parameter int PIN_W       = DEFAULT_PIN_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic [NUM_COGS*PIN_W-1:0] cog_out_i,
    input  logic [NUM_COGS*PIN_W-1:0] cog_dir_i,
    input  logic [PIN_W-1:0]          pad_in_i,
    output logic [PIN_W-1:0]          pad_out_o,
    output logic [PIN_W-1:0]          pad_oe_o,
    output logic [PIN_W-1:0]          pins_sync_o,
    input  logic [NUM_COGS-1:0]       wait_req_i,
    input  logic [NUM_COGS-1:0]       wait_mode_i,
    input  logic [NUM_COGS*PIN_W-1:0] wait_mask_i,
    input  logic [NUM_COGS*PIN_W-1:0] wait_value_i,
    input  logic [NUM_COGS-1:0]       wait_cancel_i,
    output logic [NUM_COGS-1:0]       wait_busy_o,
    output logic [NUM_COGS-1:0]       wait_done_o,
    output logic [NUM_COGS*PIN_W-1:0] wait_pins_o
);

    logic [PIN_W-1:0]                  pad_oe_d;
    logic [PIN_W-1:0]                  pad_out_d;
    logic [PIN_W-1:0]                  pad_oe_q;
    logic [PIN_W-1:0]                  pad_out_q;
    logic [SYNC_STAGES-1:0][PIN_W-1:0] sync_q;

    // A cog's OUT bit only counts where its own DIR bit is set, so an
    // undriven pin always presents out=0.
    always_comb begin
        pad_oe_d  = '0;
        pad_out_d = '0;
        for (int k = 0; k < NUM_COGS; k++) begin
            pad_oe_d  = pad_oe_d  | cog_dir_i[k*PIN_W +: PIN_W];
            pad_out_d = pad_out_d | (cog_out_i[k*PIN_W +: PIN_W] &
                                     cog_dir_i[k*PIN_W +: PIN_W]);
        end
    end

    // Register the merged pad drive and enable.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            pad_oe_q  <= '0;
            pad_out_q <= '0;
        end else begin
            pad_oe_q  <= pad_oe_d;
            pad_out_q <= pad_out_d;
        end
    end

    // Multi-stage synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pad_in_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign pad_oe_o    = pad_oe_q;
    assign pad_out_o   = pad_out_q;
    assign pins_sync_o = sync_q[SYNC_STAGES-1];

    generate
        for (genvar k = 0; k < NUM_COGS; k++) begin : g_wait
            aprop_wait_unit #(
                .PIN_W (PIN_W)
            ) u_wait (
                .clk_in   (clk_in),
                .reset_in (reset_in),
                .req_i    (wait_req_i[k]),
                .mode_i   (wait_mode_i[k]),
                .mask_i   (wait_mask_i[k*PIN_W +: PIN_W]),
                .value_i  (wait_value_i[k*PIN_W +: PIN_W]),
                .cancel_i (wait_cancel_i[k]),
                .pins_i   (sync_q[SYNC_STAGES-1]),
                .busy_o   (wait_busy_o[k]),
                .done_o   (wait_done_o[k]),
                .pins_o   (wait_pins_o[k*PIN_W +: PIN_W])
            );
        end
    endgenerate

endmodule : aprop_port_hub
`default_nettype wire

// File: tb/tb_aprop_port_hub.sv
`default_nettype none
// ============================================================================
// Module      : tb_aprop_port_hub
// Description : Self-checking bench for aprop_port_hub: directed scenarios
//               followed by randomized traffic, compared cycle by cycle
//               against a behavioural model of pins, pads and wait units.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aprop_port_hub;

    localparam int NC = 2;
    localparam int PW = 32;
    localparam int SS = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NC*PW-1:0] cog_out;
    logic [NC*PW-1:0] cog_dir;
    logic [PW-1:0]    pad_in;
    logic [PW-1:0]    pad_out;
    logic [PW-1:0]    pad_oe;
    logic [PW-1:0]    pins_sync;
    logic [NC-1:0]    wait_req;
    logic [NC-1:0]    wait_mode;
    logic [NC*PW-1:0] wait_mask;
    logic [NC*PW-1:0] wait_value;
    logic [NC-1:0]    wait_cancel;
    logic [NC-1:0]    wait_busy;
    logic [NC-1:0]    wait_done;
    logic [NC*PW-1:0] wait_pins;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    aprop_port_hub #(
        .NUM_COGS    (NC),
        .PIN_W       (PW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_in        (clk),
        .reset_in      (reset_n),
        .cog_out_i     (cog_out),
        .cog_dir_i     (cog_dir),
        .pad_in_i      (pad_in),
        .pad_out_o     (pad_out),
        .pad_oe_o      (pad_oe),
        .pins_sync_o   (pins_sync),
        .wait_req_i    (wait_req),
        .wait_mode_i   (wait_mode),
        .wait_mask_i   (wait_mask),
        .wait_value_i  (wait_value),
        .wait_cancel_i (wait_cancel),
        .wait_busy_o   (wait_busy),
        .wait_done_o   (wait_done),
        .wait_pins_o   (wait_pins)
    );

    // ---------------- reference model ----------------
    logic [PW-1:0] m_oe, m_out;
    logic [PW-1:0] pad_hist[$];     // pad values seen at recent clock edges
    bit            m_act  [NC];
    logic          m_mode [NC];
    logic [PW-1:0] m_mask [NC];
    logic [PW-1:0] m_val  [NC];
    logic [PW-1:0] m_pins [NC];
    bit            m_done [NC];

    // Pins visible to cogs: the pad value from SS edges ago, 0 until then.
    function automatic logic [PW-1:0] exp_sync();
        if (pad_hist.size() >= SS) return pad_hist[pad_hist.size()-SS];
        return '0;
    endfunction

    task automatic model_clear();
        m_oe  = '0;
        m_out = '0;
        pad_hist.delete();
        for (int k = 0; k < NC; k++) begin
            m_act[k]  = 1'b0;
            m_mode[k] = 1'b0;
            m_mask[k] = '0;
            m_val[k]  = '0;
            m_pins[k] = '0;
            m_done[k] = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [NC-1:0]    e_busy, e_done;
        logic [NC*PW-1:0] e_pins;
        for (int k = 0; k < NC; k++) begin
            e_busy[k]          = m_act[k];
            e_done[k]          = m_done[k];
            e_pins[k*PW +: PW] = m_pins[k];
        end
        check("pad_oe",    64'(pad_oe),    64'(m_oe));
        check("pad_out",   64'(pad_out),   64'(m_out));
        check("pins_sync", 64'(pins_sync), 64'(exp_sync()));
        check("busy",      64'(wait_busy), 64'(e_busy));
        check("done",      64'(wait_done), 64'(e_done));
        check("wait_pins", 64'(wait_pins), 64'(e_pins));
    endtask

    // Advance one clock: predict from current inputs, clock, then compare.
    task automatic step();
        logic [PW-1:0] cur;
        logic          en, drv, eq, fire;
        cur = exp_sync();
        for (int p = 0; p < PW; p++) begin
            en  = 1'b0;
            drv = 1'b0;
            for (int k = 0; k < NC; k++) begin
                if (cog_dir[k*PW+p]) begin
                    en = 1'b1;
                    if (cog_out[k*PW+p]) drv = 1'b1;
                end
            end
            m_oe[p]  = en;
            m_out[p] = drv;
        end
        pad_hist.push_back(pad_in);
        if (pad_hist.size() > SS) void'(pad_hist.pop_front());
        for (int k = 0; k < NC; k++) begin
            m_done[k] = 1'b0;
            if (!m_act[k]) begin
                if (wait_req[k] && !wait_cancel[k]) begin
                    m_act[k]  = 1'b1;
                    m_mode[k] = wait_mode[k];
                    m_mask[k] = wait_mask[k*PW +: PW];
                    m_val[k]  = wait_value[k*PW +: PW] & wait_mask[k*PW +: PW];
                end
            end else if (wait_cancel[k]) begin
                m_act[k] = 1'b0;
            end else begin
                eq   = ((cur & m_mask[k]) == m_val[k]);
                fire = (m_mode[k] == 1'b0) ? eq : !eq;
                if (fire) begin
                    m_act[k]  = 1'b0;
                    m_done[k] = 1'b1;
                    m_pins[k] = cur;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Mid-cycle asynchronous reset; outputs must clear without a clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        check("rst_oe",   64'(pad_oe),    64'h0);
        check("rst_out",  64'(pad_out),   64'h0);
        check("rst_sync", 64'(pins_sync), 64'h0);
        check("rst_busy", 64'(wait_busy), 64'h0);
        check("rst_done", 64'(wait_done), 64'h0);
        check("rst_pins", 64'(wait_pins), 64'h0);
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic arm(input int k, input logic mode, input logic [PW-1:0] mask,
                       input logic [PW-1:0] val);
        wait_req[k]            = 1'b1;
        wait_mode[k]           = mode;
        wait_mask[k*PW +: PW]  = mask;
        wait_value[k*PW +: PW] = val;
    endtask

    initial begin
        #2_000_000;
        n_errs++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        cog_out     = '0;
        cog_dir     = '0;
        pad_in      = '0;
        wait_req    = '0;
        wait_mode   = '0;
        wait_mask   = '0;
        wait_value  = '0;
        wait_cancel = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;

        // Output merge.
        cog_dir = {32'h0000_FF00, 32'h0000_00FF};
        cog_out = {32'h0000_0F00, 32'hFFFF_FFFF};
        step();
        check("plan_oe",  64'(pad_oe),  64'h0000_FFFF);
        check("plan_out", 64'(pad_out), 64'h0000_0FFF);
        do_reset();

        // Synchroniser latency on pad bit 5.
        pad_in = '0;
        steps(3);
        pad_in = 32'h20;
        step();
        check("sync5_t1", 64'(pins_sync[5]), 64'h0);
        step();
        check("sync5_t2", 64'(pins_sync[5]), 64'h1);

        // EQ wait, match arrives later.
        pad_in = 32'h03;
        steps(3);
        arm(0, 1'b0, 32'h0F, 32'h05);
        step();
        wait_req = '0;
        steps(2);
        pad_in = 32'h35;
        steps(2);
        check("eq_early", 64'(wait_done[0]), 64'h0);
        step();
        check("eq_done",  64'(wait_done[0]), 64'h1);
        check("eq_pins",  64'(wait_pins[31:0]), 64'h35);
        check("eq_busy",  64'(wait_busy[0]), 64'h0);
        step();
        check("eq_pulse", 64'(wait_done[0]), 64'h0);

        // NE with empty mask never completes; cancel after 10 cycles.
        arm(1, 1'b1, 32'h0, 32'h0);
        step();
        wait_req = '0;
        check("ne_busy0", 64'(wait_busy[1]), 64'h1);
        for (int i = 0; i < 9; i++) begin
            step();
            check("ne_busy", 64'(wait_busy[1]), 64'h1);
            check("ne_nodone", 64'(wait_done[1]), 64'h0);
        end
        wait_cancel[1] = 1'b1;
        step();
        wait_cancel = '0;
        check("ne_cancel_busy", 64'(wait_busy[1]), 64'h0);
        check("ne_cancel_done", 64'(wait_done[1]), 64'h0);

        // EQ with empty mask completes on the first compare.
        arm(1, 1'b0, 32'h0, 32'h0);
        step();
        wait_req = '0;
        check("eq0_busy", 64'(wait_busy[1]), 64'h1);
        step();
        check("eq0_done", 64'(wait_done[1]), 64'h1);

        // Both cogs complete together.
        pad_in = '0;
        steps(3);
        arm(0, 1'b0, 32'h1, 32'h1);
        arm(1, 1'b0, 32'h1, 32'h1);
        step();
        wait_req = '0;
        pad_in = 32'h1;
        steps(2);
        check("both_early", 64'(wait_done), 64'h0);
        step();
        check("both_done", 64'(wait_done), 64'h3);

        // Cancel on cog 0 beats its coincident match.
        pad_in = '0;
        steps(3);
        arm(0, 1'b0, 32'h1, 32'h1);
        arm(1, 1'b0, 32'h1, 32'h1);
        step();
        wait_req = '0;
        pad_in = 32'h1;
        steps(2);
        wait_cancel[0] = 1'b1;
        step();
        wait_cancel = '0;
        check("cxl_done", 64'(wait_done), 64'h2);
        check("cxl_busy", 64'(wait_busy), 64'h0);

        // Reset while waiting, then a fresh request.
        pad_in = '0;
        steps(3);
        arm(0, 1'b0, 32'hFF, 32'hAA);
        step();
        wait_req = '0;
        step();
        check("rw_busy", 64'(wait_busy[0]), 64'h1);
        do_reset();
        pad_in = 32'hAA;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rw_nodone", 64'(wait_done), 64'h0);
        end
        arm(0, 1'b0, 32'hFF, 32'hAA);
        step();
        wait_req = '0;
        check("rw_rebusy", 64'(wait_busy[0]), 64'h1);
        step();
        check("rw_done", 64'(wait_done[0]), 64'h1);
        check("rw_pins", 64'(wait_pins[31:0]), 64'hAA);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            cog_dir = {$urandom, $urandom};
            cog_out = {$urandom, $urandom};
            pad_in  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
            for (int k = 0; k < NC; k++) begin
                wait_req[k]            = ($urandom_range(0, 5) == 0);
                wait_mode[k]           = 1'($urandom_range(0, 1));
                wait_mask[k*PW +: PW]  = ($urandom_range(0, 7) == 0) ? 32'h0
                                         : 32'($urandom_range(0, 15));
                wait_value[k*PW +: PW] = $urandom;
                wait_cancel[k]         = ($urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule : tb_aprop_port_hub
`default_nettype wire
